alu4bit_core: RTL and testbench

- Registered 4-bit ALU: two operands and a 2-bit opcode are captured with a valid strobe; result and status flags are registered one cycle later.
- Used as the small arithmetic/logic slice in datapaths.
- Its results must match, bit for bit, a combinational golden model of the same opcode table.

---
 rtl/alu4bit_pkg.sv | 21 ++
 rtl/alu4bit_datapath.sv | 63 ++++++
 rtl/alu4bit_core.sv | 65 ++++++
 tb/tb_alu4bit_core.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu4bit_pkg.sv
// Shared types for the registered 4-bit ALU slice: opcode encoding,
// status flag bundle and the default datapath width.
package alu4bit_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

endpackage

// File: rtl/alu4bit_datapath.sv
// Combinational ALU datapath: (a, b, oc) -> (result, flags).
// Define ALU4BIT_SATURATE_EN for unsigned saturation on ADD/SUB.
module alu4bit_datapath
    import alu4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       oc_i,
    output logic [WIDTH-1:0] result_o,
    output flags_t           flags_o
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    opcode_e          op;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    assign op   = opcode_e'(oc_i);

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a_i[MSB] == b_i[MSB]) &&
                        (sum[MSB] != a_i[MSB]);
`ifdef ALU4BIT_SATURATE_EN
                if (sum[WIDTH]) res = '1;
`endif
            end
            (op == OP_SUB): begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a_i[MSB] != b_i[MSB]) &&
                        (diff[MSB] != a_i[MSB]);
`ifdef ALU4BIT_SATURATE_EN
                if (diff[WIDTH]) res = '0;
`endif
            end
            (op == OP_AND): res = a_i & b_i;
            default:        res = a_i | b_i;
        endcase
    end

    assign result_o      = res;
    assign flags_o.carry = carry;
    assign flags_o.ovf   = ovf;
    assign flags_o.zero  = (res == '0);
    assign flags_o.neg   = res[MSB];

endmodule

// File: rtl/alu4bit_core.sv
// Registered 4-bit ALU: one-cycle latency, result and flags held when idle.
// Optional ALU4BIT_SATURATE_EN is handled inside alu4bit_datapath.
module alu4bit_core
    import alu4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       oc,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    logic [WIDTH-1:0] res;
    flags_t           flags;

    logic [WIDTH-1:0] out_q, out_d;
    flags_t           flags_q, flags_d;
    logic             valid_q;

    alu4bit_datapath #(.WIDTH(WIDTH)) u_dp (
        .a_i      (a),
        .b_i      (b),
        .oc_i     (oc),
        .result_o (res),
        .flags_o  (flags)
    );

    always_comb begin
        out_d   = out_q;
        flags_d = flags_q;
        if (in_valid) begin
            out_d   = res;
            flags_d = flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
            valid_q <= in_valid;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign carry     = flags_q.carry;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;

endmodule

// File: tb/tb_alu4bit_core.sv
// Directed and streaming checks for alu4bit_core against hand values
// and a standalone alu4bit_datapath golden model.
module tb_alu4bit_core;
    import alu4bit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [1:0] oc = '0;
    logic [3:0] out;
    logic       out_valid, carry, ovf, zero, neg;

    logic [3:0] g_res;
    flags_t     g_flags;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu4bit_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .oc        (oc),
        .out       (out),
        .out_valid (out_valid),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    alu4bit_datapath #(.WIDTH(4)) gm (
        .a_i      (a),
        .b_i      (b),
        .oc_i     (oc),
        .result_o (g_res),
        .flags_o  (g_flags)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks out, out_valid and {carry,ovf,zero,neg}.
    task automatic chk_all(input string tag, input logic [3:0] e_out,
                           input logic e_v, input logic [3:0] e_f);
        chk({tag, ".out"}, {4'h0, out}, {4'h0, e_out});
        chk({tag, ".valid"}, {7'h0, out_valid}, {7'h0, e_v});
        chk({tag, ".flags"}, {4'h0, carry, ovf, zero, neg},
            {4'h0, e_f});
    endtask

    task automatic step(input logic [3:0] ta, input logic [3:0] tb,
                        input logic [1:0] toc);
        @(negedge clk);
        in_valid = 1'b1;
        a  = ta;
        b  = tb;
        oc = toc;
        @(negedge clk);
    endtask

    logic [3:0] exp_out;
    flags_t     exp_f;

    initial begin
        repeat (2) @(negedge clk);
        chk_all("reset", 4'h0, 1'b0, 4'b0000);
        rst_n = 1'b1;

        step(4'd3, 4'd4, 2'b00);
        chk_all("add3p4", 4'h7, 1'b1, 4'b0000);
        step(4'd7, 4'd1, 2'b00);
        chk_all("add7p1", 4'h8, 1'b1, 4'b0101);
        step(4'hF, 4'h1, 2'b00);
`ifdef ALU4BIT_SATURATE_EN
        chk_all("addwrap", 4'hF, 1'b1, 4'b1001);
`else
        chk_all("addwrap", 4'h0, 1'b1, 4'b1010);
`endif
        step(4'd5, 4'd5, 2'b01);
        chk_all("sub5m5", 4'h0, 1'b1, 4'b0010);
        step(4'd2, 4'd5, 2'b01);
`ifdef ALU4BIT_SATURATE_EN
        chk_all("sub2m5", 4'h0, 1'b1, 4'b1010);
`else
        chk_all("sub2m5", 4'hD, 1'b1, 4'b1001);
`endif
        step(4'h0, 4'h1, 2'b01);
`ifdef ALU4BIT_SATURATE_EN
        chk_all("sub0m1", 4'h0, 1'b1, 4'b1010);
`else
        chk_all("sub0m1", 4'hF, 1'b1, 4'b1001);
`endif
        step(4'h8, 4'h1, 2'b01);
        chk_all("subovf", 4'h7, 1'b1, 4'b0100);
        step(4'hC, 4'hA, 2'b10);
        chk_all("and", 4'h8, 1'b1, 4'b0001);
        step(4'hC, 4'hA, 2'b11);
        chk_all("or", 4'hE, 1'b1, 4'b0001);

        // Asynchronous reset mid-stream with in_valid still high.
        @(negedge clk);
        a = 4'd3; b = 4'd4; oc = 2'b00; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 4'h0, 1'b0, 4'b0000);
        @(negedge clk);
        chk_all("rst_held", 4'h0, 1'b0, 4'b0000);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_all("post_rst_idle", 4'h0, 1'b0, 4'b0000);
        step(4'd1, 4'd1, 2'b00);
        chk_all("post_rst_op", 4'h2, 1'b1, 4'b0000);

        // Back-to-back stream compared to the golden model one cycle late.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("stream.out", {4'h0, out}, {4'h0, exp_out});
                chk("stream.valid", {7'h0, out_valid}, 8'h1);
                chk("stream.flags", {4'h0, carry, ovf, zero, neg},
                    {4'h0, exp_f});
            end
            in_valid = 1'b1;
            a  = 4'($urandom_range(15));
            b  = 4'($urandom_range(15));
            oc = 2'($urandom_range(3));
            #1;
            exp_out = g_res;
            exp_f   = g_flags;
        end
        @(negedge clk);
        chk("stream_last.out", {4'h0, out}, {4'h0, exp_out});
        chk("stream_last.flags", {4'h0, carry, ovf, zero, neg},
            {4'h0, exp_f});
        in_valid = 1'b0;
        a = ~a;
        b = ~b;
        repeat (2) @(negedge clk);
        chk("idle.valid", {7'h0, out_valid}, 8'h0);
        chk("idle.out", {4'h0, out}, {4'h0, exp_out});
        chk("idle.flags", {4'h0, carry, ovf, zero, neg}, {4'h0, exp_f});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
